// File: rtl/elevator_request_queue_pkg.sv
// Shared encodings and defaults for the elevator request queue and its floor scanner.
package elevator_request_queue_pkg;

    localparam int N_FLOORS_DEF = 5;
    localparam int FLOOR_W_DEF  = 3;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = DIR_IDLE,
        ST_UP   = DIR_UP,
        ST_DOWN = DIR_DOWN
    } dir_state_t;

endpackage

// File: rtl/elevator_floor_scan.sv
// Combinational priority search over a request vector, restricted to floors at/above
// (ABOVE=1) or at/below (ABOVE=0) cur, returning the lowest or highest (PICK_HIGH) hit.
module elevator_floor_scan
    import elevator_request_queue_pkg::*;
#(
    parameter int N_FLOORS  = N_FLOORS_DEF,
    parameter int FLOOR_W   = FLOOR_W_DEF,
    parameter bit ABOVE     = 1'b1,
    parameter bit PICK_HIGH = 1'b0
) (
    input  logic [N_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]  cur,
    output logic                found,
    output logic [FLOOR_W-1:0]  floor_idx
);

    // Ascending scan: the first hit is the lowest, the last hit is the highest.
    always_comb begin
        found     = 1'b0;
        floor_idx = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (req[i] && (ABOVE ? (i >= int'(cur)) : (i <= int'(cur)))) begin
                if (PICK_HIGH || !found) begin
                    found     = 1'b1;
                    floor_idx = FLOOR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/elevator_request_queue.sv
// Latches hall/cabin calls and runs a SCAN scheduler that feeds the elevator controller.
// Define ELEV_REQ_SYNC_EN to pass fb/sb/buttons through 2-flop synchronizers before capture.
module elevator_request_queue
    import elevator_request_queue_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = FLOOR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] fb,
    input  logic [N_FLOORS-1:0] sb,
    input  logic [N_FLOORS-1:0] buttons,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                arrived,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic [1:0]          dir,
    output logic [N_FLOORS-1:0] pending
);

    localparam logic [FLOOR_W:0]   N_IDX   = (FLOOR_W+1)'(N_FLOORS);
    localparam logic [N_FLOORS-1:0] FB_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] SB_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    dir_state_t          state;
    logic [N_FLOORS-1:0] up_req, dn_req, cab_req, all_req;
    logic [N_FLOORS-1:0] fb_in, sb_in, btn_in;
    logic [N_FLOORS-1:0] up_clr, dn_clr, cab_clr;
    logic [N_FLOORS-1:0] cur_onehot;
    logic                cur_ok;

`ifdef ELEV_REQ_SYNC_EN
    logic [N_FLOORS-1:0] fb_meta, sb_meta, btn_meta;
    logic [N_FLOORS-1:0] fb_sync, sb_sync, btn_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_meta  <= '0;
            sb_meta  <= '0;
            btn_meta <= '0;
            fb_sync  <= '0;
            sb_sync  <= '0;
            btn_sync <= '0;
        end else begin
            fb_meta  <= fb;
            sb_meta  <= sb;
            btn_meta <= buttons;
            fb_sync  <= fb_meta;
            sb_sync  <= sb_meta;
            btn_sync <= btn_meta;
        end
    end

    assign fb_in  = fb_sync;
    assign sb_in  = sb_sync;
    assign btn_in = btn_sync;
`else
    assign fb_in  = fb;
    assign sb_in  = sb;
    assign btn_in = buttons;
`endif

    assign all_req    = up_req | dn_req | cab_req;
    assign pending    = all_req;
    assign dir        = state;
    assign cur_ok     = ({1'b0, cur_floor} < N_IDX);
    assign cur_onehot = cur_ok ? (N_FLOORS'(1) << cur_floor) : '0;

    logic                up_lo_found, any_above, dn_hi_found, any_below;
    logic [FLOOR_W-1:0]  up_lo_idx, above_hi_idx, dn_hi_idx, below_lo_idx;
    logic [FLOOR_W-1:0]  up_target, dn_target;
    logic                ahead_up, ahead_dn;

    elevator_floor_scan #(
        .N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b1), .PICK_HIGH(1'b0)
    ) u_scan_up_near (
        .req(cab_req | up_req), .cur(cur_floor), .found(up_lo_found), .floor_idx(up_lo_idx)
    );

    elevator_floor_scan #(
        .N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b1), .PICK_HIGH(1'b1)
    ) u_scan_up_far (
        .req(all_req & ~cur_onehot), .cur(cur_floor), .found(any_above), .floor_idx(above_hi_idx)
    );

    elevator_floor_scan #(
        .N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b0), .PICK_HIGH(1'b1)
    ) u_scan_dn_near (
        .req(cab_req | dn_req), .cur(cur_floor), .found(dn_hi_found), .floor_idx(dn_hi_idx)
    );

    elevator_floor_scan #(
        .N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b0), .PICK_HIGH(1'b0)
    ) u_scan_dn_far (
        .req(all_req & ~cur_onehot), .cur(cur_floor), .found(any_below), .floor_idx(below_lo_idx)
    );

    // Prefer calls travelling our way; otherwise run out to the farthest request before turning.
    assign up_target = up_lo_found ? up_lo_idx : above_hi_idx;
    assign dn_target = dn_hi_found ? dn_hi_idx : below_lo_idx;
    assign ahead_up  = up_lo_found | any_above;
    assign ahead_dn  = dn_hi_found | any_below;

    always_comb begin
        cab_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (arrived && cur_ok) begin
            cab_clr = cur_onehot;
            case (state)
                ST_UP: begin
                    up_clr = cur_onehot;
                    if (!any_above) dn_clr = cur_onehot;
                end
                ST_DOWN: begin
                    dn_clr = cur_onehot;
                    if (!any_below) up_clr = cur_onehot;
                end
                default: begin
                    up_clr = cur_onehot;
                    dn_clr = cur_onehot;
                end
            endcase
        end
    end

    // Clearing is applied before the OR so a press landing with arrival survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_req  <= '0;
            dn_req  <= '0;
            cab_req <= '0;
        end else begin
            up_req  <= (up_req  & ~up_clr)  | (fb_in & FB_MASK);
            dn_req  <= (dn_req  & ~dn_clr)  | (sb_in & SB_MASK);
            cab_req <= (cab_req & ~cab_clr) | btn_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            target_floor <= '0;
            target_valid <= 1'b0;
        end else if (!cur_ok) begin
            target_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_above) begin
                        state        <= ST_UP;
                        target_floor <= up_target;
                        target_valid <= 1'b1;
                    end else if (any_below) begin
                        state        <= ST_DOWN;
                        target_floor <= dn_target;
                        target_valid <= 1'b1;
                    end else if (|(all_req & cur_onehot)) begin
                        target_floor <= cur_floor;
                        target_valid <= 1'b1;
                    end else begin
                        target_valid <= 1'b0;
                    end
                end
                ST_UP: begin
                    if (ahead_up) begin
                        target_floor <= up_target;
                        target_valid <= 1'b1;
                    end else if (any_below) begin
                        state        <= ST_DOWN;
                        target_floor <= dn_target;
                        target_valid <= 1'b1;
                    end else begin
                        state        <= ST_IDLE;
                        target_valid <= 1'b0;
                    end
                end
                ST_DOWN: begin
                    if (ahead_dn) begin
                        target_floor <= dn_target;
                        target_valid <= 1'b1;
                    end else if (any_above) begin
                        state        <= ST_UP;
                        target_floor <= up_target;
                        target_valid <= 1'b1;
                    end else begin
                        state        <= ST_IDLE;
                        target_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    target_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Scoreboard bench for elevator_request_queue: expected outputs are queued as stimulus is applied.
module tb_elevator_request_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] fb, sb, buttons;
    logic [2:0] cur_floor;
    logic       arrived;
    logic [2:0] target_floor;
    logic       target_valid;
    logic [1:0] dir;
    logic [4:0] pending;

    int compared   = 0;
    int mismatched = 0;

`ifdef ELEV_REQ_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    typedef struct packed {
        logic [1:0] d;
        logic       v;
        logic [2:0] t;
        logic [4:0] p;
    } obs_t;

    typedef struct packed {
        logic [2:0] c;
        logic [4:0] f;
        logic [4:0] s;
        logic [4:0] b;
        logic       a;
        obs_t       e;
    } step_t;

    obs_t exp_q[$];
    int   lat_q[$];

    elevator_request_queue dut (
        .clk(clk), .reset(reset), .fb(fb), .sb(sb), .buttons(buttons),
        .cur_floor(cur_floor), .arrived(arrived), .target_floor(target_floor),
        .target_valid(target_valid), .dir(dir), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic step_t mk(input logic [2:0] c, input logic [4:0] f, input logic [4:0] s,
                                 input logic [4:0] b, input logic a, input logic [1:0] d,
                                 input logic v, input logic [2:0] t, input logic [4:0] p);
        step_t r;
        r.c = c; r.f = f; r.s = s; r.b = b; r.a = a;
        r.e.d = d; r.e.v = v; r.e.t = t; r.e.p = p;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {dir, target_valid, target_floor, pending};
        return o;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        fb = '0; sb = '0; buttons = '0; arrived = 1'b0; cur_floor = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic play(input step_t s);
        cur_floor = s.c; fb = s.f; sb = s.s; buttons = s.b; arrived = s.a;
        exp_q.push_back(s.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        reset = 1'b0; fb = '0; sb = '0; buttons = 5'b11111; arrived = 1'b0; cur_floor = '0;
        exp_q.push_back(obs_t'(0));
        #12;
        got = observe();
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %b expected %b", got, exp);
        end
        @(negedge clk);
        buttons = '0;
        reset = 1'b1;
    endtask

    task automatic test_capture_latency();
        int lat;
        pulse_reset();
        lat_q.push_back(1 + SYNC_EXTRA);
        buttons = 5'b01000;
        @(posedge clk);
        #1;
        buttons = '0;
        lat = 1;
        while (!pending[3] && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        compared++;
        if (lat != lat_q[0]) begin
            mismatched++;
            $display("[TB] FAIL capture_latency: got %0d edges expected %0d", lat, lat_q[0]);
        end
        void'(lat_q.pop_front());
    endtask

    task automatic test_idle_to_up();
        step_t st[$];
        obs_t  got, exp;
        pulse_reset();
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b10000, 0, 2'b00, 0, 0, 5'b10000));
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10000));
        st.push_back(mk(1, 5'b00100, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10100));
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 2, 5'b10100));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL idle_to_up[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    // Continues from test_idle_to_up: UP toward 2 with cab 4 still pending.
    task automatic test_arrival_clear();
        step_t st[$];
        obs_t  got, exp;
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 2, 5'b10100));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 1, 2'b01, 1, 2, 5'b10000));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10000));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10000));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 1, 2'b01, 1, 4, 5'b00000));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 0, 4, 5'b00000));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL arrival_clear[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    task automatic test_turnaround();
        step_t st[$];
        obs_t  got, exp;
        pulse_reset();
        st.push_back(mk(2, 5'b00000, 5'b10000, 5'b10001, 0, 2'b00, 0, 0, 5'b10001));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10001));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 4, 5'b10001));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 1, 2'b01, 1, 4, 5'b00001));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 0, 2'b10, 1, 0, 5'b00001));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL turnaround[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    // Continues from test_turnaround: DOWN at floor 4 heading for cab 0.
    task automatic test_set_wins();
        step_t st[$];
        obs_t  got, exp;
        st.push_back(mk(4, 5'b00000, 5'b00100, 5'b00000, 0, 2'b10, 1, 0, 5'b00101));
        st.push_back(mk(4, 5'b00000, 5'b00000, 5'b00000, 0, 2'b10, 1, 2, 5'b00101));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b10, 1, 2, 5'b00101));
        st.push_back(mk(2, 5'b00000, 5'b00100, 5'b00000, 1, 2'b10, 1, 2, 5'b00101));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b10, 1, 2, 5'b00101));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 1, 2'b10, 1, 2, 5'b00001));
        st.push_back(mk(2, 5'b00000, 5'b00000, 5'b00000, 0, 2'b10, 1, 0, 5'b00001));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL set_wins[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    // Continues from test_set_wins: DOWN toward cab 0; also checks the ignored edge hall bits.
    task automatic test_bottom_floor();
        step_t st[$];
        obs_t  got, exp;
        st.push_back(mk(0, 5'b00001, 5'b00000, 5'b00000, 0, 2'b10, 1, 0, 5'b00001));
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 2'b10, 1, 0, 5'b00000));
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 0, 0, 5'b00000));
        st.push_back(mk(0, 5'b10000, 5'b00001, 5'b00000, 0, 2'b00, 0, 0, 5'b00000));
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 0, 0, 5'b00000));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL bottom_floor[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    task automatic test_idle_at_cur();
        step_t st[$];
        obs_t  got, exp;
        pulse_reset();
        st.push_back(mk(3, 5'b01000, 5'b01000, 5'b01000, 0, 2'b00, 0, 0, 5'b01000));
        st.push_back(mk(3, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 1, 3, 5'b01000));
        st.push_back(mk(3, 5'b00000, 5'b00000, 5'b00000, 1, 2'b00, 1, 3, 5'b00000));
        st.push_back(mk(3, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 0, 3, 5'b00000));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL idle_at_cur[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    task automatic test_invalid_floor();
        step_t st[$];
        obs_t  got, exp;
        pulse_reset();
        st.push_back(mk(5, 5'b00000, 5'b00000, 5'b00010, 0, 2'b00, 0, 0, 5'b00010));
        st.push_back(mk(5, 5'b00000, 5'b00000, 5'b00000, 1, 2'b00, 0, 0, 5'b00010));
        st.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 1, 5'b00010));
        st.push_back(mk(7, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 0, 1, 5'b00010));
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 1, 5'b00010));
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 1, 2'b01, 1, 1, 5'b00000));
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 2'b00, 0, 1, 5'b00000));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL invalid_floor[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t st[$];
        obs_t  got, exp;
        pulse_reset();
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b10110, 0, 2'b00, 0, 0, 5'b10110));
        st.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 2'b01, 1, 1, 5'b10110));
        foreach (st[i]) begin
            play(st[i]);
            got = observe();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL async_reset_pre[%0d]: got dir=%b vld=%b tgt=%0d pend=%b expected dir=%b vld=%b tgt=%0d pend=%b",
                         i, got.d, got.v, got.t, got.p, exp.d, exp.v, exp.t, exp.p);
            end
        end
        exp_q.push_back(obs_t'(0));
        #2;
        reset = 1'b0;
        #1;
        got = observe();
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got %b expected %b", got, exp);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        $display("[TB] starting elevator_request_queue bench");
        test_reset();
        test_capture_latency();
`ifndef ELEV_REQ_SYNC_EN
        test_idle_to_up();
        test_arrival_clear();
        test_turnaround();
        test_set_wins();
        test_bottom_floor();
        test_idle_at_cur();
        test_invalid_floor();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
